// File: rtl/branch_pkg.sv
// Shared types and default widths for the decision-tree branch stage.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_IDX_W    = 4;

endpackage

// File: rtl/branch_compare.sv
// Selects one feature field of the sample and compares it with the node threshold.
// Optional macro BRANCH_GE_COMPARE_EN turns the strict > compare into >=.
module branch_compare
  import branch_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [IDX_W-1:0]    feat_sel,
  input  logic [DATA_W-1:0]   threshold,
  output logic                go_right
);

  localparam int NUM_FEAT = SAMPLE_W / DATA_W;

  logic [IDX_W-1:0]  sel_mod_s;
  logic [DATA_W-1:0] feature_s;

  assign sel_mod_s = feat_sel % IDX_W'(NUM_FEAT);

  // Feature multiplexer: out-of-range selects wrap modulo the feature count
  always_comb begin
    feature_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (sel_mod_s == IDX_W'(i)) begin
        feature_s = sample[i*DATA_W +: DATA_W];
      end else begin
        feature_s = feature_s;
      end
    end
  end

`ifdef BRANCH_GE_COMPARE_EN
  assign go_right = (feature_s >= threshold);
`else
  assign go_right = (feature_s > threshold);
`endif

endmodule

// File: rtl/internal_branch_stage_fixed.sv
// One level of a pipelined decision tree: fetch node parameters, pick the child,
// forward the sample right and the child index down. Optional macro: BRANCH_GE_COMPARE_EN.
module internal_branch_stage_fixed
  import branch_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                    memRdy,
  input  logic                    nodeValidIn,
  input  logic                    sampValidIn,
  output logic                    inReady,
  output logic                    nodeValidOut,
  output logic                    sampValidOut,
  input  logic                    bottomReady,
  input  logic                    rightReady,
  input  logic [SAMPLE_W-1:0]     sampIn,
  output logic [SAMPLE_W-1:0]     sampOut,
  input  logic [IDX_W-1:0]        nodeIdxIn,
  output logic [IDX_W-1:0]        nodeIdxOut,
  input  logic [IDX_W+DATA_W-1:0] nodeParams,
  output logic [IDX_W-1:0]        nodeAddrOut,
  input  logic                    clk,
  input  logic                    rst
);

  state_t              state_r, state_nxt_s;
  logic [SAMPLE_W-1:0] samp_r;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    child_r;
  logic                node_valid_r, samp_valid_r;
  logic                node_valid_nxt_s, samp_valid_nxt_s;
  logic                capture_s, fetch_done_s;
  logic                go_right_s;
  logic [IDX_W-1:0]    feat_sel_s;
  logic [DATA_W-1:0]   thr_s;

  assign feat_sel_s = nodeParams[IDX_W+DATA_W-1:DATA_W];
  assign thr_s      = nodeParams[DATA_W-1:0];

  branch_compare #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_compare (
    .sample    (samp_r),
    .feat_sel  (feat_sel_s),
    .threshold (thr_s),
    .go_right  (go_right_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus independent clearing of the two output handshakes
  always_comb begin
    state_nxt_s      = state_r;
    node_valid_nxt_s = node_valid_r;
    samp_valid_nxt_s = samp_valid_r;
    capture_s        = 1'b0;
    fetch_done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (sampValidIn && nodeValidIn) begin
          capture_s   = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (memRdy) begin
          fetch_done_s     = 1'b1;
          node_valid_nxt_s = 1'b1;
          samp_valid_nxt_s = 1'b1;
          state_nxt_s      = OUTPUT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      OUTPUT: begin
        if (node_valid_r && bottomReady) begin
          node_valid_nxt_s = 1'b0;
        end else begin
          node_valid_nxt_s = node_valid_r;
        end
        if (samp_valid_r && rightReady) begin
          samp_valid_nxt_s = 1'b0;
        end else begin
          samp_valid_nxt_s = samp_valid_r;
        end
        if (!node_valid_nxt_s && !samp_valid_nxt_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUTPUT;
        end
      end
      default: begin
        state_nxt_s      = IDLE;
        node_valid_nxt_s = 1'b0;
        samp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_r       <= {SAMPLE_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      child_r      <= {IDX_W{1'b0}};
      node_valid_r <= 1'b0;
      samp_valid_r <= 1'b0;
    end else begin
      node_valid_r <= node_valid_nxt_s;
      samp_valid_r <= samp_valid_nxt_s;
      if (capture_s) begin
        samp_r <= sampIn;
        idx_r  <= nodeIdxIn;
      end
      if (fetch_done_s) begin
        child_r <= {idx_r[IDX_W-2:0], go_right_s};
      end
    end
  end

  assign inReady      = (state_r == IDLE) && !rst;
  assign nodeValidOut = node_valid_r;
  assign sampValidOut = samp_valid_r;
  assign sampOut      = samp_r;
  assign nodeIdxOut   = child_r;
  // Address follows the live input while idle so the fetch can start early
  assign nodeAddrOut  = (state_r == IDLE) ? nodeIdxIn : idx_r;

endmodule

// File: tb/tb_internal_branch_stage_fixed.sv
// Self-checking bench for internal_branch_stage_fixed: directed table, random
// transactions against a field-arithmetic model, and reset corner cases.
module tb_internal_branch_stage_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRdy, nodeValidIn, sampValidIn, inReady;
  logic        nodeValidOut, sampValidOut, bottomReady, rightReady;
  logic [15:0] sampIn, sampOut;
  logic [3:0]  nodeIdxIn, nodeIdxOut, nodeAddrOut;
  logic [7:0]  nodeParams;

  int checks = 0;
  int errors = 0;

  internal_branch_stage_fixed dut (
    .memRdy(memRdy), .nodeValidIn(nodeValidIn), .sampValidIn(sampValidIn),
    .inReady(inReady), .nodeValidOut(nodeValidOut), .sampValidOut(sampValidOut),
    .bottomReady(bottomReady), .rightReady(rightReady),
    .sampIn(sampIn), .sampOut(sampOut), .nodeIdxIn(nodeIdxIn), .nodeIdxOut(nodeIdxOut),
    .nodeParams(nodeParams), .nodeAddrOut(nodeAddrOut), .clk(clk), .rst(rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] samp;
    logic [3:0]  idx;
    logic [7:0]  params;
    int          mem_dly;
    int          bot_dly;
    int          rgt_dly;
    logic [3:0]  exp_child;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Child index from the node rule: pick field (sel mod 4), compare, 2*idx+goRight mod 16
  function automatic logic [3:0] model_child(input logic [15:0] s, input logic [3:0] idx,
                                             input logic [7:0] p);
    int f, feat, thr, gr;
    f    = int'(p[7:4]) % 4;
    feat = (int'(s) >> (4 * f)) % 16;
    thr  = int'(p[3:0]);
`ifdef BRANCH_GE_COMPARE_EN
    gr = (feat >= thr) ? 1 : 0;
`else
    gr = (feat > thr) ? 1 : 0;
`endif
    return 4'((int'(idx) * 2 + gr) % 16);
  endfunction

  task automatic run_txn(input logic [15:0] s, input logic [3:0] idx, input logic [7:0] p,
                         input int md, input int bd, input int rd, input logic [3:0] exp);
    bit nv, sv;
    int c;
    @(negedge clk);
    chk("idle_inready", inReady, 1);
    sampValidIn = 1'b1; nodeValidIn = 1'b1; sampIn = s; nodeIdxIn = idx;
    nodeParams = p; memRdy = 1'b0; bottomReady = 1'b0; rightReady = 1'b0;
    #1 chk("idle_addr", nodeAddrOut, idx);
    @(negedge clk);
    sampValidIn = 1'b0; nodeValidIn = 1'b0;
    sampIn = 16'($urandom); nodeIdxIn = 4'($urandom);
    for (int i = 0; i < md; i++) begin
      chk("fetch_wait_inready", inReady, 0);
      chk("fetch_wait_nvalid", nodeValidOut, 0);
      chk("fetch_wait_svalid", sampValidOut, 0);
      @(negedge clk);
    end
    chk("fetch_addr", nodeAddrOut, idx);
    memRdy = 1'b1;
    @(negedge clk);
    memRdy = 1'b0;
    nodeParams = 8'($urandom);
    chk("out_nvalid", nodeValidOut, 1);
    chk("out_svalid", sampValidOut, 1);
    chk("out_child", nodeIdxOut, exp);
    chk("out_samp", sampOut, s);
    chk("out_addr", nodeAddrOut, idx);
    nv = 1'b1; sv = 1'b1; c = 0;
    while ((nv || sv) && c < 64) begin
      chk("out_inready", inReady, 0);
      bottomReady = (c >= bd);
      rightReady  = (c >= rd);
      @(negedge clk);
      if (nv && bottomReady) nv = 1'b0;
      if (sv && rightReady)  sv = 1'b0;
      chk("hs_nvalid", nodeValidOut, nv);
      chk("hs_svalid", sampValidOut, sv);
      if (nv) chk("hs_child_stable", nodeIdxOut, exp);
      if (sv) chk("hs_samp_stable", sampOut, s);
      c++;
    end
    if (nv || sv) begin
      checks++; errors++;
      $display("FAIL hs_timeout actual=pending expected=done");
    end
    bottomReady = 1'b0; rightReady = 1'b0;
    chk("back_to_idle", inReady, 1);
  endtask

  initial begin
    vecs[0] = '{16'h0F3A, 4'd1,  8'h06, 0, 0, 0, 4'd3};
    vecs[1] = '{16'h0F3A, 4'd3,  8'h16, 0, 0, 0, 4'd6};
    vecs[2] = '{16'h0F3A, 4'd2,  8'h26, 5, 0, 0, 4'd5};
    vecs[3] = '{16'h0F3A, 4'd5,  8'h16, 0, 4, 0, 4'hA};
`ifdef BRANCH_GE_COMPARE_EN
    vecs[4] = '{16'h1236, 4'd4,  8'h06, 1, 1, 2, 4'd9};
`else
    vecs[4] = '{16'h1236, 4'd4,  8'h06, 1, 1, 2, 4'd8};
`endif
    vecs[5] = '{16'hF000, 4'hF,  8'h30, 2, 0, 0, 4'hF};
    vecs[6] = '{16'h0F3A, 4'd0,  8'h52, 0, 2, 2, 4'd1};
    vecs[7] = '{16'h0F3A, 4'hF,  8'h36, 0, 0, 3, 4'hE};

    rst = 1'b1; memRdy = 1'b0; nodeValidIn = 1'b0; sampValidIn = 1'b0;
    bottomReady = 1'b0; rightReady = 1'b0; sampIn = 16'h0; nodeIdxIn = 4'h0; nodeParams = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_inready", inReady, 0);
    chk("rst_nvalid", nodeValidOut, 0);
    chk("rst_svalid", sampValidOut, 0);
    chk("rst_samp", sampOut, 16'h0);
    chk("rst_child", nodeIdxOut, 4'h0);
    rst = 1'b0;

    // Only one of the two input valids must not start a transaction
    @(negedge clk);
    sampValidIn = 1'b1; sampIn = 16'hBEEF;
    @(negedge clk);
    chk("partial_valid_inready", inReady, 1);
    sampValidIn = 1'b0; nodeValidIn = 1'b1;
    @(negedge clk);
    chk("partial_valid2_inready", inReady, 1);
    nodeValidIn = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].samp, vecs[i].idx, vecs[i].params,
              vecs[i].mem_dly, vecs[i].bot_dly, vecs[i].rgt_dly, vecs[i].exp_child);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] s;
      logic [3:0]  idx;
      logic [7:0]  p;
      s = 16'($urandom); idx = 4'($urandom); p = 8'($urandom);
      run_txn(s, idx, p, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), model_child(s, idx, p));
    end

    // Reset while both outputs are pending
    @(negedge clk);
    sampValidIn = 1'b1; nodeValidIn = 1'b1; sampIn = 16'h1234; nodeIdxIn = 4'd2;
    nodeParams = 8'h00; memRdy = 1'b1;
    @(negedge clk);
    sampValidIn = 1'b0; nodeValidIn = 1'b0;
    @(negedge clk);
    memRdy = 1'b0;
    chk("pre_rst_nvalid", nodeValidOut, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_nvalid", nodeValidOut, 0);
    chk("rst_out_svalid", sampValidOut, 0);
    chk("rst_out_inready", inReady, 0);
    chk("rst_out_samp", sampOut, 16'h0);
    chk("rst_out_child", nodeIdxOut, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inready", inReady, 1);
    run_txn(16'h0F3A, 4'd1, 8'h06, 0, 0, 0, 4'd3);

    // Reset while waiting on memory
    @(negedge clk);
    sampValidIn = 1'b1; nodeValidIn = 1'b1; sampIn = 16'h5555; nodeIdxIn = 4'd7; memRdy = 1'b0;
    @(negedge clk);
    sampValidIn = 1'b0; nodeValidIn = 1'b0;
    chk("fetch_pre_rst_inready", inReady, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    memRdy = 1'b1;
    @(negedge clk);
    memRdy = 1'b0;
    chk("fetch_rst_nvalid", nodeValidOut, 0);
    chk("fetch_rst_inready", inReady, 1);
    run_txn(16'h0F3A, 4'd3, 8'h16, 1, 0, 0, 4'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/internal_branch_stage_fixed.md
INTERNAL_BRANCH_STAGE_FIXED -- requirements
Module: internal_branch_stage_fixed

Interface
REQ-001 SHALL have parameter DATA_W, default 4: bits per feature and per threshold.
REQ-002 SHALL have parameter SAMPLE_W, default 16: sample width; NUM_FEAT = SAMPLE_W/DATA_W.
REQ-003 SHALL have parameter IDX_W, default 4: node index width and feature-select width.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports, in positional order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- memRdy  in  1  nodeParams valid for nodeAddrOut
- nodeValidIn  in  1  node index from stage above valid
- sampValidIn  in  1  sample from left valid
- inReady  out  1  stage accepts sample and index (shared by left and above)
- nodeValidOut  out  1  child index to stage below valid
- sampValidOut  out  1  sample to right valid
- bottomReady  in  1  stage below accepts index
- rightReady  in  1  stage to right accepts sample
- sampIn  in  SAMPLE_W  sample
- sampOut  out  SAMPLE_W  forwarded sample
- nodeIdxIn  in  IDX_W  current node index
- nodeIdxOut  out  IDX_W  child node index
- nodeParams  in  IDX_W+DATA_W  {featureSel[IDX_W-1:0], threshold[DATA_W-1:0]}
- nodeAddrOut  out  IDX_W  node index for parameter fetch
- clk, rst are the final two positional ports; the order above is otherwise exact.

Function
REQ-006 SHALL implement FSM with states IDLE, FETCH, OUTPUT.
REQ-007 IDLE: inReady=1; when sampValidIn && nodeValidIn, capture sampIn and nodeIdxIn, go to FETCH; otherwise stay.
REQ-008 FETCH: nodeAddrOut = captured index; inReady=0; wait while memRdy=0; when memRdy=1, register results, set both valids, go to OUTPUT.
REQ-009 Feature = captured sample bits [f*DATA_W +: DATA_W], f = featureSel mod NUM_FEAT.
REQ-010 goRight = (feature > threshold), unsigned.
REQ-011 nodeIdxOut = {capturedIdx[IDX_W-2:0], goRight} (2*idx+goRight, truncated to IDX_W).
REQ-012 sampOut = captured sample unchanged.
REQ-013 Latency: outputs valid one clock after the FETCH cycle in which memRdy is high; back-to-back minimum throughput is one sample per 3 clocks.
REQ-014 OUTPUT: nodeValidOut clears at the edge where nodeValidOut && bottomReady; sampValidOut clears at the edge where sampValidOut && rightReady; the two handshakes are independent and may complete in the same or different cycles.
REQ-015 OUTPUT goes to IDLE at the edge where the last pending valid clears; inReady stays 0 throughout OUTPUT.
REQ-016 Output data SHALL remain stable while the corresponding valid is high.
REQ-017 nodeAddrOut equals the captured index in FETCH and OUTPUT, and nodeIdxIn in IDLE.

Reset
REQ-018 While rst=1: state IDLE, inReady=0, both valids 0, sampOut=0, nodeIdxOut=0.
REQ-019 Reset mid-FETCH or mid-OUTPUT SHALL drop data in flight; inReady=1 on the first clock after rst falls.

Configuration
REQ-020 With macro BRANCH_GE_COMPARE_EN defined, goRight = (feature >= threshold); without it, strict > (REQ-010).

Structure
REQ-021 Package branch_pkg SHALL hold the FSM state enum (IDLE, FETCH, OUTPUT) and default widths DATA_W=4, SAMPLE_W=16, IDX_W=4.
REQ-022 A combinational sub-module branch_compare (feature select plus compare, output goRight) is natural; the remainder is the FSM and registers.

Verification
REQ-023 sampIn=16'h0F3A, nodeIdxIn=1, nodeParams=8'h06, memRdy=1, both downstream readys=1 -> nodeIdxOut=3, sampOut=16'h0F3A, both valids for one cycle.
REQ-024 sampIn=16'h0F3A, nodeIdxIn=3, nodeParams=8'h16 -> nodeIdxOut=6 (feature 3 <= 6, left).
REQ-025 memRdy held 0 for 5 cycles in FETCH -> no valid, inReady=0; valid one clock after memRdy rises.
REQ-026 rightReady=1, bottomReady=0 for 4 cycles -> sampValidOut clears after one cycle, nodeValidOut held with stable index, inReady=0 until bottomReady rises, then IDLE.
REQ-027 feature == threshold (sample field0=6, threshold 6) -> left child without BRANCH_GE_COMPARE_EN, right child with it.
REQ-028 rst asserted during OUTPUT -> valids 0 next edge; new input accepted after release.
